// File: rtl/secded_decoder.sv
// secded_decoder: reads 16-bit SECDED codewords, corrects/flags errors, writes 11-bit data plus status.
// Optional error counters are built when SECDED_STATS_EN is defined.
module secded_decoder #(
    parameter int IN_BASE   = 30,
    parameter int OUT_BASE  = 0,
    parameter int NUM_WORDS = 15,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data,
    output logic [3:0]    err1_count,
    output logic [3:0]    err2_count
);
    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE} state_t;

    state_t state, nxt;
    logic [3:0] idx;
    logic [7:0] lo, hi, dlo, dhi;
    logic [15:0] w, c;
    logic [3:0] s;
    logic [1:0] f;
    logic p, accept;
    logic [AW-1:0] off;

    assign w      = {hi, lo};
    assign off    = AW'({idx, 1'b0});
    assign accept = (state == IDLE || state == DONE) && start;

    always_comb begin
        s = '0;
        for (int k = 1; k < 16; k++)
            if (w[k]) s = s ^ 4'(k);
        p = ^w;
        c = p ? w ^ (16'b1 << s) : w;
        f = p ? 2'b01 : (s != 4'd0 ? 2'b10 : 2'b00);
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE: nxt = start ? RD_LO : state;
            RD_LO:      nxt = RD_HI;
            RD_HI:      nxt = DECODE;
            DECODE:     nxt = WR_LO;
            WR_LO:      nxt = WR_HI;
            WR_HI:      nxt = (idx == 4'(NUM_WORDS - 1)) ? DONE : RD_LO;
            default:    nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state)
            RD_LO: mem_addr = AW'(IN_BASE) + off;
            RD_HI: mem_addr = AW'(IN_BASE) + off + AW'(1);
            WR_LO: begin
                mem_addr    = AW'(OUT_BASE) + off;
                mem_wr_en   = 1'b1;
                mem_wr_data = dlo;
            end
            WR_HI: begin
                mem_addr    = AW'(OUT_BASE) + off + AW'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = dhi;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            lo    <= '0;
            hi    <= '0;
            dlo   <= '0;
            dhi   <= '0;
            done  <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                idx  <= '0;
                done <= 1'b0;
            end else if (state == DONE) done <= 1'b1;
            if (state == RD_LO) lo <= mem_rd_data;
            if (state == RD_HI) hi <= mem_rd_data;
            if (state == DECODE) begin
                dlo <= {c[12:9], c[7:5], c[3]};
                dhi <= {f, 3'b000, c[15:13]};
            end
            if (state == WR_HI) idx <= idx + 4'd1;
        end
    end

`ifdef SECDED_STATS_EN
    logic [3:0] e1, e2;
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            e1 <= '0;
            e2 <= '0;
        end else if (state == DECODE) begin
            if (f == 2'b01 && e1 != 4'hF) e1 <= e1 + 4'd1;
            if (f == 2'b10 && e2 != 4'hF) e2 <= e2 + 4'd1;
        end
    end
    assign err1_count = e1;
    assign err2_count = e2;
`else
    assign err1_count = 4'd0;
    assign err2_count = 4'd0;
`endif
endmodule

// File: tb/tb_secded_decoder.sv
// tb_secded_decoder: table-driven and scoreboard checks of secded_decoder against a nearest-codeword model.
module tb_secded_decoder;
    typedef struct {
        logic [15:0] cw;
        logic [7:0]  lo;
        logic [7:0]  hi;
    } vec_t;
    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 0;
    logic       reset = 1;
    logic       start = 0;
    logic       done, mem_wr_en;
    logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
    logic [3:0] err1_count, err2_count;
    logic [7:0] in_mem [64];
    logic [7:0] out_mem [256];
    vec_t tbl [15];
    wr_t  exp_q [$];
    wr_t  obs_q [$];
    int   wr_cnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_e1, exp_e2;

    always #5 clk = ~clk;

    secded_decoder dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .err1_count(err1_count), .err2_count(err2_count)
    );

    assign mem_rd_data = (mem_addr >= 8'd30 && mem_addr < 8'd60) ? in_mem[mem_addr - 8'd30] : out_mem[mem_addr];

    always @(posedge clk) if (mem_wr_en) out_mem[mem_addr] <= mem_wr_data;

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_cnt++;
            obs_q.push_back('{mem_addr, mem_wr_data});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] enc(input logic [10:0] d);
        int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] w;
        logic [3:0] p;
        w = '0;
        p = '0;
        for (int i = 0; i < 11; i++)
            if (d[i]) begin
                w[pos[i]] = 1'b1;
                p = p ^ 4'(pos[i]);
            end
        w[1] = p[0];
        w[2] = p[1];
        w[4] = p[2];
        w[8] = p[3];
        w[0] = ^w[15:1];
        return w;
    endfunction

    // Decode by searching for a codeword within Hamming distance 1.
    function automatic vec_t mk(input logic [15:0] w);
        vec_t v;
        logic [10:0] d;
        int n;
        v.cw = w;
        v.lo = {w[12], w[11], w[10], w[9], w[7], w[6], w[5], w[3]};
        v.hi = {2'b10, 3'b000, w[15:13]};
        for (int k = 0; k < 2048; k++) begin
            d = 11'(k);
            n = $countones(enc(d) ^ w);
            if (n < 2) begin
                v.lo = d[7:0];
                v.hi = {(n == 1) ? 2'b01 : 2'b00, 3'b000, d[10:8]};
                break;
            end
        end
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        logic [15:0] w;
        int nf, b1, b2;
        w  = enc(11'($urandom_range(0, 2047)));
        nf = $urandom_range(0, 2);
        b1 = $urandom_range(0, 15);
        b2 = (b1 + $urandom_range(1, 15)) % 16;
        if (nf >= 1) w[b1] = ~w[b1];
        if (nf == 2) w[b2] = ~w[b2];
        return mk(w);
    endfunction

    task automatic load();
        exp_e1 = 0;
        exp_e2 = 0;
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < 15; i++) begin
            in_mem[2*i]   = tbl[i].cw[7:0];
            in_mem[2*i+1] = tbl[i].cw[15:8];
            exp_q.push_back('{8'(2*i), tbl[i].lo});
            exp_q.push_back('{8'(2*i+1), tbl[i].hi});
            if (tbl[i].hi[7:6] == 2'b01 && exp_e1 < 15) exp_e1++;
            if (tbl[i].hi[7:6] == 2'b10 && exp_e2 < 15) exp_e2++;
        end
    endtask

    task automatic drain(input int n);
        wr_t e, o;
        for (int i = 0; i < n && exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk($sformatf("wr_addr[%0d]", i), o.a, e.a);
            chk($sformatf("wr_data[%0d]", i), o.d, e.d);
        end
    endtask

    task automatic run(input bit mid);
        int n, w0;
        @(negedge clk);
        start = 1;
        w0 = wr_cnt;
        @(posedge clk);
        #1 start = 0;
        chk("done_cleared", done, 0);
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (mid && n == 30) start = 1;
            if (mid && n == 31) start = 0;
        end
        chk("done_latency", n, 76);
        chk("wr_cycles", wr_cnt - w0, 30);
        chk("obs_count", obs_q.size(), 30);
        drain(30);
`ifdef SECDED_STATS_EN
        chk("err1_count", err1_count, exp_e1);
        chk("err2_count", err2_count, exp_e2);
`else
        chk("err1_count", err1_count, 0);
        chk("err2_count", err2_count, 0);
`endif
    endtask

    initial begin
        int w1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_done", done, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wr_data, 0);
        chk("rst_err1", err1_count, 0);
        chk("rst_err2", err2_count, 0);
        reset = 0;

        tbl[0] = '{16'h0000, 8'h00, 8'h00};
        tbl[1] = '{16'hFFFF, 8'hFF, 8'h07};
        tbl[2] = '{16'hFFDF, 8'hFF, 8'h47};
        tbl[3] = '{16'hFFFE, 8'hFF, 8'h47};
        tbl[4] = '{16'h0208, 8'h11, 8'h80};
        for (int i = 5; i < 15; i++) tbl[i] = rnd_vec();
        load();
        run(1);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("tbl_lo[%0d]", i), out_mem[2*i], tbl[i].lo);
            chk($sformatf("tbl_hi[%0d]", i), out_mem[2*i+1], tbl[i].hi);
        end

        for (int i = 0; i < 15; i++) tbl[i] = rnd_vec();
        load();
        run(0);

        for (int i = 0; i < 15; i++) tbl[i] = rnd_vec();
        load();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (20) @(posedge clk);
        #1 reset = 1;
        @(posedge clk);
        #1 reset = 0;
        w1 = wr_cnt;
        chk("rst_mid_writes", obs_q.size(), 8);
        drain(8);
        exp_q.delete();
        obs_q.delete();
        repeat (100) @(posedge clk);
        #1;
        chk("rst_no_writes", wr_cnt - w1, 0);
        chk("rst_done_low", done, 0);

        for (int i = 0; i < 15; i++) tbl[i] = rnd_vec();
        load();
        run(0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("post_lo[%0d]", i), out_mem[2*i], tbl[i].lo);
            chk($sformatf("post_hi[%0d]", i), out_mem[2*i+1], tbl[i].hi);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
